// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_unit
// Description : EX-stage branch/jump resolution with a saturating-counter BHT
//               looked up at IF, plus saturating branch/mispredict statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 2,
    parameter int CNT_INIT    = 1,
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   if_pc,
    output logic              if_pred_taken,
    input  logic              ex_valid,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic [1:0]        ex_j_type,
    input  logic [2:0]        ex_branch_t,
    input  logic              ex_zero,
    input  logic              ex_lt,
    input  logic              ex_ltu,
    input  logic              ex_pred_taken,
    output logic              flush,
    output logic [1:0]        pc_sel,
    output logic [STAT_W-1:0] br_count,
    output logic [STAT_W-1:0] mispred_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    localparam logic [CNT_W-1:0]  c_cnt_max  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  c_cnt_zero = '0;
    localparam logic [CNT_W-1:0]  c_cnt_rst  = CNT_W'(CNT_INIT);
    localparam logic [STAT_W-1:0] c_stat_max = {STAT_W{1'b1}};

    localparam logic [1:0] c_j_jal    = 2'b01;
    localparam logic [1:0] c_j_jalr   = 2'b10;
    localparam logic [1:0] c_j_branch = 2'b11;

    localparam logic [1:0] c_sel_pc4     = 2'b00;
    localparam logic [1:0] c_sel_target  = 2'b01;
    localparam logic [1:0] c_sel_jalr    = 2'b10;
    localparam logic [1:0] c_sel_recover = 2'b11;

    logic [CNT_W-1:0]  bht_q [BHT_ENTRIES];
    logic [STAT_W-1:0] br_count_q,  br_count_d;
    logic [STAT_W-1:0] mispred_q,   mispred_d;

    logic [IDX_W-1:0]  w_if_idx;
    logic [IDX_W-1:0]  w_ex_idx;
    logic              w_legal_br;
    logic              w_actual;
    logic              w_mispred;
    logic [CNT_W-1:0]  w_cnt_cur;
    logic [CNT_W-1:0]  w_cnt_d;
    logic              w_unused_bits;

    assign w_if_idx      = if_pc[IDX_W+1:2];
    assign w_ex_idx      = ex_pc[IDX_W+1:2];
    assign w_unused_bits = ^{if_pc, ex_pc};

    // Lookup returns the stored value only; a same-cycle update is not bypassed.
    assign w_cnt_cur     = bht_q[w_ex_idx];
    assign if_pred_taken = bht_q[w_if_idx][CNT_W-1];

    always_comb begin
        w_legal_br = 1'b0;
        w_actual   = 1'b0;
        if (ex_valid && (ex_j_type == c_j_branch)) begin
            w_legal_br = 1'b1;
            case (ex_branch_t)
                3'b000:  w_actual = ex_zero;
                3'b001:  w_actual = !ex_zero;
                3'b100:  w_actual = ex_lt;
                3'b101:  w_actual = !ex_lt;
                3'b110:  w_actual = ex_ltu;
                3'b111:  w_actual = !ex_ltu;
                default: w_legal_br = 1'b0;
            endcase
        end
    end

    assign w_mispred = w_legal_br && (w_actual != ex_pred_taken);

    always_comb begin
        flush  = 1'b0;
        pc_sel = c_sel_pc4;
        if (ex_valid && (ex_j_type == c_j_jal)) begin
            flush  = 1'b1;
            pc_sel = c_sel_target;
        end else if (ex_valid && (ex_j_type == c_j_jalr)) begin
            flush  = 1'b1;
            pc_sel = c_sel_jalr;
        end else if (w_mispred) begin
            flush  = 1'b1;
            pc_sel = w_actual ? c_sel_target : c_sel_recover;
        end
    end

    always_comb begin
        w_cnt_d = w_cnt_cur;
        if (w_actual) begin
            if (w_cnt_cur != c_cnt_max) w_cnt_d = w_cnt_cur + 1'b1;
        end else begin
            if (w_cnt_cur != c_cnt_zero) w_cnt_d = w_cnt_cur - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= c_cnt_rst;
            end
        end else if (w_legal_br) begin
            bht_q[w_ex_idx] <= w_cnt_d;
        end
    end

    // Statistics saturate at all-ones rather than wrapping.
    always_comb begin
        br_count_d = br_count_q;
        mispred_d  = mispred_q;
        if (w_legal_br) begin
            if (br_count_q != c_stat_max) br_count_d = br_count_q + 1'b1;
            if (w_mispred && (mispred_q != c_stat_max)) mispred_d = mispred_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_q <= '0;
            mispred_q  <= '0;
        end else begin
            br_count_q <= br_count_d;
            mispred_q  <= mispred_d;
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predict_unit
// Description : Self-checking bench for branch_predict_unit (two STAT_W sizes).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] if_pc = '0;
    logic [31:0] ex_pc = '0;
    logic        ex_valid = 1'b0;
    logic [1:0]  ex_j_type = '0;
    logic [2:0]  ex_branch_t = '0;
    logic        ex_zero = 1'b0, ex_lt = 1'b0, ex_ltu = 1'b0, ex_pred_taken = 1'b0;

    logic        pred_a, flush_a, pred_b, flush_b;
    logic [1:0]  sel_a, sel_b;
    logic [15:0] br_a, mis_a;
    logic [2:0]  br_b, mis_b;

    always #5 clk = ~clk;

    branch_predict_unit #(.STAT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(pred_a),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_j_type(ex_j_type),
        .ex_branch_t(ex_branch_t), .ex_zero(ex_zero), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
        .ex_pred_taken(ex_pred_taken), .flush(flush_a), .pc_sel(sel_a),
        .br_count(br_a), .mispred_count(mis_a)
    );

    branch_predict_unit #(.STAT_W(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(pred_b),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_j_type(ex_j_type),
        .ex_branch_t(ex_branch_t), .ex_zero(ex_zero), .ex_lt(ex_lt), .ex_ltu(ex_ltu),
        .ex_pred_taken(ex_pred_taken), .flush(flush_b), .pc_sel(sel_b),
        .br_count(br_b), .mispred_count(mis_b)
    );

    // Reference state: one integer per BHT slot, plain integer statistics.
    int bht_m [64];
    int br16, mis16, br3, mis3;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int idx(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic int pred_of(input logic [31:0] pc);
        return (bht_m[idx(pc)] >= 2) ? 1 : 0;
    endfunction

    function automatic void ref_resolve(output bit f, output int s, output bit legal, output bit tk);
        f = 0; s = 0; legal = 0; tk = 0;
        if (!ex_valid) return;
        if (ex_j_type == 2'd1) begin f = 1; s = 1; end
        else if (ex_j_type == 2'd2) begin f = 1; s = 2; end
        else if (ex_j_type == 2'd3) begin
            legal = 1;
            case (ex_branch_t)
                3'd0: tk = ex_zero;
                3'd1: tk = !ex_zero;
                3'd4: tk = ex_lt;
                3'd5: tk = !ex_lt;
                3'd6: tk = ex_ltu;
                3'd7: tk = !ex_ltu;
                default: legal = 0;
            endcase
            if (legal && (tk != ex_pred_taken)) begin
                f = 1;
                s = tk ? 1 : 3;
            end
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) bht_m[i] = 1;
        br16 = 0; mis16 = 0; br3 = 0; mis3 = 0;
    endfunction

    // Inputs are driven at the negedge; check combinational outputs, clock once,
    // advance the model, then check state at the following negedge.
    task automatic step(input string tag);
        bit f, legal, tk;
        int s, i;
        #2;
        ref_resolve(f, s, legal, tk);
        chk({tag, " flush"}, flush_a, f);
        chk({tag, " pc_sel"}, sel_a, s);
        chk({tag, " flush_b"}, flush_b, f);
        chk({tag, " pc_sel_b"}, sel_b, s);
        chk({tag, " pred_pre"}, pred_a, pred_of(if_pc));
        @(posedge clk);
        if (legal) begin
            i = idx(ex_pc);
            bht_m[i] = tk ? ((bht_m[i] < 3) ? bht_m[i] + 1 : 3)
                          : ((bht_m[i] > 0) ? bht_m[i] - 1 : 0);
            br16 = (br16 < 65535) ? br16 + 1 : 65535;
            br3  = (br3 < 7) ? br3 + 1 : 7;
            if (tk != ex_pred_taken) begin
                mis16 = (mis16 < 65535) ? mis16 + 1 : 65535;
                mis3  = (mis3 < 7) ? mis3 + 1 : 7;
            end
        end
        @(negedge clk);
        chk({tag, " pred_post"}, pred_a, pred_of(if_pc));
        chk({tag, " pred_post_b"}, pred_b, pred_of(if_pc));
        chk({tag, " br_count"}, br_a, br16);
        chk({tag, " mispred_count"}, mis_a, mis16);
        chk({tag, " br_count_b"}, br_b, br3);
        chk({tag, " mispred_count_b"}, mis_b, mis3);
    endtask

    task automatic do_reset(input string tag);
        logic [31:0] pcs [4];
        pcs[0] = 32'h40; pcs[1] = 32'h80; pcs[2] = 32'hC0; pcs[3] = 32'h0;
        @(negedge clk);
        #3;
        ex_valid = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        #1;
        chk({tag, " rst br_count"}, br_a, 0);
        chk({tag, " rst mispred_count"}, mis_a, 0);
        chk({tag, " rst br_count_b"}, br_b, 0);
        for (int k = 0; k < 4; k++) begin
            if_pc = pcs[k];
            #1;
            chk({tag, " rst pred"}, pred_a, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [1:0] jt,
                         input logic [2:0] bt, input logic z, input logic lt,
                         input logic ltu, input logic pr, input logic [31:0] ipc);
        ex_valid = v; ex_pc = pc; ex_j_type = jt; ex_branch_t = bt;
        ex_zero = z; ex_lt = lt; ex_ltu = ltu; ex_pred_taken = pr; if_pc = ipc;
    endtask

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [1:0]  jt;
        logic [2:0]  bt;
        logic        z, lt, ltu, pr;
        logic [31:0] ipc;
        logic        e_flush;
        logic [1:0]  e_sel;
        logic        e_pred;
    } vec_t;

    vec_t vt [16];

    initial begin
        vt[0]  = '{1, 32'h40,  2'b11, 3'b000, 1, 0, 0, 0, 32'h40,  1, 2'b01, 1};
        vt[1]  = '{1, 32'h80,  2'b11, 3'b001, 0, 0, 0, 0, 32'h80,  1, 2'b01, 1};
        vt[2]  = '{1, 32'h80,  2'b11, 3'b001, 0, 0, 0, 1, 32'h80,  0, 2'b00, 1};
        vt[3]  = '{1, 32'h80,  2'b11, 3'b001, 0, 0, 0, 1, 32'h80,  0, 2'b00, 1};
        vt[4]  = '{1, 32'h80,  2'b11, 3'b001, 0, 0, 0, 1, 32'h80,  0, 2'b00, 1};
        vt[5]  = '{1, 32'h80,  2'b11, 3'b001, 1, 0, 0, 1, 32'h80,  1, 2'b11, 1};
        vt[6]  = '{1, 32'h80,  2'b11, 3'b111, 0, 0, 1, 1, 32'h80,  1, 2'b11, 0};
        vt[7]  = '{1, 32'hC0,  2'b11, 3'b100, 0, 1, 0, 1, 32'hC0,  0, 2'b00, 1};
        vt[8]  = '{1, 32'h100, 2'b01, 3'b000, 1, 0, 0, 0, 32'h100, 1, 2'b01, 0};
        vt[9]  = '{1, 32'h40,  2'b10, 3'b000, 1, 0, 0, 0, 32'h40,  1, 2'b10, 1};
        vt[10] = '{0, 32'h80,  2'b11, 3'b000, 1, 0, 0, 0, 32'h80,  0, 2'b00, 0};
        vt[11] = '{1, 32'h80,  2'b11, 3'b010, 1, 1, 1, 1, 32'h80,  0, 2'b00, 0};
        vt[12] = '{1, 32'hC0,  2'b11, 3'b011, 0, 1, 0, 0, 32'hC0,  0, 2'b00, 1};
        vt[13] = '{1, 32'hC0,  2'b11, 3'b110, 0, 0, 0, 0, 32'hC0,  0, 2'b00, 0};
        vt[14] = '{1, 32'h44,  2'b11, 3'b101, 0, 0, 0, 0, 32'h44,  1, 2'b01, 1};
        vt[15] = '{1, 32'h140, 2'b11, 3'b001, 1, 0, 0, 1, 32'h40,  1, 2'b11, 0};

        do_reset("init");

        for (int k = 0; k < 16; k++) begin
            drive(vt[k].v, vt[k].pc, vt[k].jt, vt[k].bt, vt[k].z, vt[k].lt,
                  vt[k].ltu, vt[k].pr, vt[k].ipc);
            #1;
            chk($sformatf("vec%0d flush", k), flush_a, vt[k].e_flush);
            chk($sformatf("vec%0d pc_sel", k), sel_a, vt[k].e_sel);
            step($sformatf("vec%0d", k));
            chk($sformatf("vec%0d pred_after", k), pred_a, vt[k].e_pred);
        end
        chk("table br_count", br_a, 11);
        chk("table mispred_count", mis_a, 6);
        chk("table br_count_b", br_b, 7);

        // Nine mispredicted taken branches saturate the 3-bit statistics.
        do_reset("sat");
        for (int k = 0; k < 9; k++) begin
            drive(1, 32'h40, 2'b11, 3'b000, 1, 0, 0, 0, 32'h40);
            step("sat");
        end
        chk("sat br_count_b", br_b, 7);
        chk("sat mispred_count_b", mis_b, 7);
        chk("sat br_count", br_a, 9);
        chk("sat mispred_count", mis_a, 9);

        // Counter at 3: two not-taken updates with a same-index lookup.
        drive(1, 32'h40, 2'b11, 3'b000, 0, 0, 0, 1, 32'h40);
        step("same0");
        #2;
        chk("same1 pred_pre", pred_a, 1);
        step("same1");
        chk("same1 pred_post", pred_a, 0);

        for (int k = 0; k < 400; k++) begin
            logic [31:0] pc;
            if (k == 200) do_reset("mid");
            pc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            drive(($urandom % 4) != 0, pc, 2'($urandom), 3'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  (($urandom % 3) == 0) ? pc : {22'd0, 8'($urandom), 2'b00});
            step($sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
